// File: rtl/shape_setup_pkg.sv
// Shared constants, types and the rotation trig table for the per-frame shape setup stage.
package shape_setup_pkg;

    localparam int NUM_SHAPES     = 7;
    localparam int ROT_STEPS      = 8;
    localparam int INT_BITS       = 16;
    localparam int FLOAT_BITS     = 32;
    localparam int FLOAT_DCM_BITS = 12;

    localparam int IDX_W = $clog2(NUM_SHAPES);
    localparam int ROT_W = $clog2(ROT_STEPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHAPES - 1);

    localparam int Q_ONE = 1 << FLOAT_DCM_BITS;
    // 46341 / 2^16 approximates sqrt(2)/2; the +2^15 rounds to nearest.
    localparam int Q_HALF_SQRT2 = (Q_ONE * 46341 + 32768) >>> 16;

    typedef logic signed [FLOAT_BITS-1:0] fixed_t;

    localparam fixed_t SIN_LUT [ROT_STEPS] = '{
        0, Q_HALF_SQRT2, Q_ONE, Q_HALF_SQRT2,
        0, -Q_HALF_SQRT2, -Q_ONE, -Q_HALF_SQRT2
    };

    typedef struct packed {
        fixed_t sin;
        fixed_t cos;
    } trig_t;

    typedef struct packed {
        logic [INT_BITS-1:0] x;
        logic [INT_BITS-1:0] y;
        logic [ROT_W-1:0]    rot;
        logic [INT_BITS-1:0] ty;
        logic [INT_BITS-1:0] size;
        logic                vis;
    } shape_entry_t;

    typedef struct packed {
        logic [INT_BITS-1:0] ty;
        logic [INT_BITS-1:0] size;
        fixed_t              sin;
        fixed_t              cos;
        fixed_t              ix;
        fixed_t              iy;
        logic                vis;
    } shape_params_t;

    typedef enum logic [1:0] {
        MAC_X_COS = 2'd0,
        MAC_Y_SIN = 2'd1,
        MAC_X_SIN = 2'd2,
        MAC_Y_COS = 2'd3
    } mac_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL0,
        ST_MUL1,
        ST_MUL2,
        ST_MUL3,
        ST_STORE,
        ST_READY
    } state_t;

    // cos(a) = sin(a + 90 deg), a quarter turn further round the table.
    function automatic trig_t trig_lut(input logic [ROT_W-1:0] rot);
        trig_t            t;
        logic [ROT_W-1:0] cos_idx;
        cos_idx = rot + ROT_W'(ROT_STEPS / 4);
        t.sin   = SIN_LUT[rot];
        t.cos   = SIN_LUT[cos_idx];
        return t;
    endfunction

endpackage

// File: rtl/shape_setup_mac.sv
// Shared signed multiplier with the ix/iy accumulators; one product per enabled cycle.
module shape_setup_mac
    import shape_setup_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr,
    input  logic                         i_en,
    input  logic [1:0]                   i_op,
    input  logic [INT_BITS-1:0]          i_x,
    input  logic [INT_BITS-1:0]          i_y,
    input  logic signed [FLOAT_BITS-1:0] i_sin,
    input  logic signed [FLOAT_BITS-1:0] i_cos,
    output logic signed [FLOAT_BITS-1:0] o_ix,
    output logic signed [FLOAT_BITS-1:0] o_iy
);

    mac_op_t w_op;
    fixed_t  w_x;
    fixed_t  w_y;
    fixed_t  w_a;
    fixed_t  w_b;
    fixed_t  w_prod;
    fixed_t  r_ix;
    fixed_t  r_iy;

    assign w_op   = mac_op_t'(i_op);
    assign w_x    = $signed({{(FLOAT_BITS-INT_BITS){1'b0}}, i_x});
    assign w_y    = $signed({{(FLOAT_BITS-INT_BITS){1'b0}}, i_y});
    assign w_prod = w_a * w_b;

    // NOTE: every variable written in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_a = w_x;
        w_b = i_cos;
        case (w_op)
            MAC_X_COS: begin w_a = w_x; w_b = i_cos; end
            MAC_Y_SIN: begin w_a = w_y; w_b = i_sin; end
            MAC_X_SIN: begin w_a = w_x; w_b = i_sin; end
            MAC_Y_COS: begin w_a = w_y; w_b = i_cos; end
            default:   begin w_a = w_x; w_b = i_cos; end
        endcase
    end

    // ix = -(x*cos - y*sin), iy = -(x*sin + y*cos), built up one term per cycle.
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ix <= '0;
            r_iy <= '0;
        end else if (i_en) begin
            case (w_op)
                MAC_X_COS: r_ix <= r_ix - w_prod;
                MAC_Y_SIN: r_ix <= r_ix + w_prod;
                MAC_X_SIN: r_iy <= r_iy - w_prod;
                MAC_Y_COS: r_iy <= r_iy - w_prod;
                default:   r_ix <= r_ix;
            endcase
        end
    end

    assign o_ix = r_ix;
    assign o_iy = r_iy;

endmodule

// File: rtl/shape_setup.sv
// Vblank setup for the shape rasterisers: computes trig steps and local origins per shape
// into a shadow bank, committed to the rasteriser-facing bank on newframe.
module shape_setup
    import shape_setup_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [INT_BITS-1:0]          wr_x,
    input  logic [INT_BITS-1:0]          wr_y,
    input  logic [ROT_W-1:0]             wr_rot,
    input  logic [INT_BITS-1:0]          wr_ty,
    input  logic [INT_BITS-1:0]          wr_size,
    input  logic                         wr_vis,
    input  logic                         start,
    input  logic                         newframe,
    output logic                         busy,
    output logic                         late,
    output logic [INT_BITS-1:0]          o_ty   [NUM_SHAPES],
    output logic [INT_BITS-1:0]          o_size [NUM_SHAPES],
    output logic signed [FLOAT_BITS-1:0] o_sin  [NUM_SHAPES],
    output logic signed [FLOAT_BITS-1:0] o_cos  [NUM_SHAPES],
    output logic signed [FLOAT_BITS-1:0] o_ix   [NUM_SHAPES],
    output logic signed [FLOAT_BITS-1:0] o_iy   [NUM_SHAPES],
    output logic                         o_vis  [NUM_SHAPES]
);

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_idx;
    shape_entry_t        r_table  [NUM_SHAPES];
    shape_params_t       r_shadow [NUM_SHAPES];
    shape_params_t       r_bank   [NUM_SHAPES];
    shape_entry_t        w_wr_entry;
    shape_entry_t        w_load_entry;
    logic [INT_BITS-1:0] r_x;
    logic [INT_BITS-1:0] r_y;
    logic [INT_BITS-1:0] r_ty;
    logic [INT_BITS-1:0] r_size;
    logic                r_vis;
    trig_t               r_trig;
    logic                r_late;
    logic                w_mac_clr;
    logic                w_mac_en;
    mac_op_t             w_mac_op;
    fixed_t              w_ix;
    fixed_t              w_iy;

    assign w_wr_entry   = '{x: wr_x, y: wr_y, rot: wr_rot, ty: wr_ty, size: wr_size, vis: wr_vis};
    assign w_load_entry = r_table[r_idx];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_MUL0;
            ST_MUL0:  w_state_next = ST_MUL1;
            ST_MUL1:  w_state_next = ST_MUL2;
            ST_MUL2:  w_state_next = ST_MUL3;
            ST_MUL3:  w_state_next = ST_STORE;
            ST_STORE: w_state_next = (r_idx == LAST_IDX) ? ST_READY : ST_LOAD;
            // A start coinciding with the commit is accepted after the commit.
            ST_READY: if (newframe) w_state_next = start ? ST_LOAD : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        w_mac_clr = 1'b0;
        w_mac_en  = 1'b0;
        w_mac_op  = MAC_X_COS;
        case (r_state)
            ST_LOAD:  begin busy = 1'b1; w_mac_clr = 1'b1; end
            ST_MUL0:  begin busy = 1'b1; w_mac_en = 1'b1; w_mac_op = MAC_X_COS; end
            ST_MUL1:  begin busy = 1'b1; w_mac_en = 1'b1; w_mac_op = MAC_Y_SIN; end
            ST_MUL2:  begin busy = 1'b1; w_mac_en = 1'b1; w_mac_op = MAC_X_SIN; end
            ST_MUL3:  begin busy = 1'b1; w_mac_en = 1'b1; w_mac_op = MAC_Y_COS; end
            ST_STORE: busy = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    shape_setup_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_mac_clr),
        .i_en  (w_mac_en),
        .i_op  (w_mac_op),
        .i_x   (r_x),
        .i_y   (r_y),
        .i_sin (r_trig.sin),
        .i_cos (r_trig.cos),
        .o_ix  (w_ix),
        .o_iy  (w_iy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table and both banks are flop arrays, reset so that a reset blanks every shape on screen.
            for (int k = 0; k < NUM_SHAPES; k++) begin
                r_table[k]  <= '0;
                r_shadow[k] <= '0;
                r_bank[k]   <= '0;
            end
            r_idx  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_ty   <= '0;
            r_size <= '0;
            r_vis  <= 1'b0;
            r_trig <= '0;
            r_late <= 1'b0;
        end else begin
            if (wr_en && (wr_idx <= LAST_IDX)) r_table[wr_idx] <= w_wr_entry;
            r_late <= newframe && busy;
            case (r_state)
                ST_IDLE: if (start) r_idx <= '0;
                ST_LOAD: begin
                    r_x    <= w_load_entry.x;
                    r_y    <= w_load_entry.y;
                    r_ty   <= w_load_entry.ty;
                    r_size <= w_load_entry.size;
                    r_vis  <= w_load_entry.vis;
                    r_trig <= trig_lut(w_load_entry.rot);
                end
                ST_STORE: begin
                    r_shadow[r_idx] <= '{ty: r_ty, size: r_size, sin: r_trig.sin, cos: r_trig.cos,
                                         ix: w_ix, iy: w_iy, vis: r_vis};
                    if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                end
                ST_READY: begin
                    if (newframe) begin
                        r_bank <= r_shadow;
                        if (start) r_idx <= '0;
                    end
                end
                default: r_idx <= r_idx;
            endcase
        end
    end

    assign late = r_late;

    always_comb begin
        for (int k = 0; k < NUM_SHAPES; k++) begin
            o_ty[k]   = r_bank[k].ty;
            o_size[k] = r_bank[k].size;
            o_sin[k]  = r_bank[k].sin;
            o_cos[k]  = r_bank[k].cos;
            o_ix[k]   = r_bank[k].ix;
            o_iy[k]   = r_bank[k].iy;
            o_vis[k]  = r_bank[k].vis;
        end
    end

endmodule

// File: tb/tb_shape_setup.sv
// Directed bench for shape_setup: a frame-level model checked every cycle plus literal pins.
module tb_shape_setup;
    import shape_setup_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst = 1'b1;
    logic                         wr_en = 1'b0;
    logic [IDX_W-1:0]             wr_idx = '0;
    logic [INT_BITS-1:0]          wr_x = '0, wr_y = '0, wr_ty = '0, wr_size = '0;
    logic [ROT_W-1:0]             wr_rot = '0;
    logic                         wr_vis = 1'b0;
    logic                         start = 1'b0, newframe = 1'b0;
    logic                         busy, late;
    logic [INT_BITS-1:0]          o_ty [NUM_SHAPES], o_size [NUM_SHAPES];
    logic signed [FLOAT_BITS-1:0] o_sin [NUM_SHAPES], o_cos [NUM_SHAPES];
    logic signed [FLOAT_BITS-1:0] o_ix [NUM_SHAPES], o_iy [NUM_SHAPES];
    logic                         o_vis [NUM_SHAPES];

    shape_setup dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_rot(wr_rot), .wr_ty(wr_ty), .wr_size(wr_size), .wr_vis(wr_vis),
        .start(start), .newframe(newframe), .busy(busy), .late(late),
        .o_ty(o_ty), .o_size(o_size), .o_sin(o_sin), .o_cos(o_cos),
        .o_ix(o_ix), .o_iy(o_iy), .o_vis(o_vis)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct { int x; int y; int rot; int ty; int size; int vis; } m_entry_t;
    typedef struct { longint ty; longint size; longint s; longint c; longint ix; longint iy; longint vis; } m_params_t;

    m_entry_t  m_table  [NUM_SHAPES];
    m_entry_t  m_pend   [NUM_SHAPES];
    m_params_t m_shadow [NUM_SHAPES];
    m_params_t m_bank   [NUM_SHAPES];
    bit        m_computing = 1'b0, m_ready = 1'b0, m_late = 1'b0;
    int        m_k = 0;

    function automatic m_params_t model_setup(input m_entry_t e);
        m_params_t p;
        real       ang;
        longint    s, c, ix, iy;
        ang  = 2.0 * 3.14159265358979 * e.rot / 8.0;
        s    = longint'(4096.0 * $sin(ang));
        c    = longint'(4096.0 * $cos(ang));
        ix   = -(e.x * c - e.y * s);
        iy   = -(e.x * s + e.y * c);
        p.ty = e.ty; p.size = e.size; p.vis = e.vis;
        p.s  = s;    p.c = c;
        p.ix = longint'(int'(ix));
        p.iy = longint'(int'(iy));
        return p;
    endfunction

    // A frame takes 6 cycles per shape; entry i is sampled at the start of its 6-cycle slot.
    initial forever begin
        bit was_computing;
        @(posedge clk);
        if (rst) begin
            m_computing = 1'b0; m_ready = 1'b0; m_late = 1'b0; m_k = 0;
            for (int i = 0; i < NUM_SHAPES; i++) begin
                m_table[i]  = '{0, 0, 0, 0, 0, 0};
                m_shadow[i] = '{0, 0, 0, 0, 0, 0, 0};
                m_bank[i]   = '{0, 0, 0, 0, 0, 0, 0};
            end
        end else begin
            was_computing = m_computing;
            m_late = newframe && was_computing;
            if (m_computing) begin
                if (m_k % 6 == 0) m_pend[m_k / 6] = m_table[m_k / 6];
                m_k++;
                if (m_k == 6 * NUM_SHAPES) begin
                    m_computing = 1'b0;
                    m_ready     = 1'b1;
                    for (int i = 0; i < NUM_SHAPES; i++) m_shadow[i] = model_setup(m_pend[i]);
                end
            end else if (m_ready) begin
                if (newframe) begin
                    m_bank  = m_shadow;
                    m_ready = 1'b0;
                    if (start) begin m_computing = 1'b1; m_k = 0; end
                end
            end else if (start) begin
                m_computing = 1'b1; m_k = 0;
            end
            if (wr_en && int'(wr_idx) < NUM_SHAPES)
                m_table[int'(wr_idx)] = '{int'(wr_x), int'(wr_y), int'(wr_rot), int'(wr_ty), int'(wr_size), int'(wr_vis)};
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("busy", busy, m_computing);
            check("late", late, m_late);
            for (int i = 0; i < NUM_SHAPES; i++) begin
                n_checks++;
                if ($isunknown({o_ty[i], o_size[i], o_sin[i], o_cos[i], o_ix[i], o_iy[i], o_vis[i]}) ||
                    longint'(o_ty[i]) != m_bank[i].ty || longint'(o_size[i]) != m_bank[i].size ||
                    longint'(o_sin[i]) != m_bank[i].s || longint'(o_cos[i]) != m_bank[i].c ||
                    longint'(o_ix[i]) != m_bank[i].ix || longint'(o_iy[i]) != m_bank[i].iy ||
                    longint'(o_vis[i]) != m_bank[i].vis) begin
                    n_fail++;
                    $display("FAIL shape%0d @%0t: got ty=%0d size=%0d sin=%0d cos=%0d ix=%0d iy=%0d vis=%0d expected ty=%0d size=%0d sin=%0d cos=%0d ix=%0d iy=%0d vis=%0d",
                             i, $time, o_ty[i], o_size[i], o_sin[i], o_cos[i], o_ix[i], o_iy[i], o_vis[i],
                             m_bank[i].ty, m_bank[i].size, m_bank[i].s, m_bank[i].c, m_bank[i].ix, m_bank[i].iy, m_bank[i].vis);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_entry(input int idx, input int x, input int y, input int rot, input int ty, input int size, input bit vis);
        wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_x = INT_BITS'(x); wr_y = INT_BITS'(y);
        wr_rot = ROT_W'(rot); wr_ty = INT_BITS'(ty); wr_size = INT_BITS'(size); wr_vis = vis;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_newframe();
        newframe = 1'b1; @(negedge clk); newframe = 1'b0;
    endtask

    task automatic wait_not_busy(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check({name, " ready within bound"}, (n < 200), 1);
    endtask

    // x, y, rot, ty, size, vis for the initial table (entry 0 is overwritten by test 1).
    int init_tab [NUM_SHAPES][6] = '{
        '{100, 50, 0, 1, 20, 1}, '{320, 240, 1, 0, 64, 1}, '{7, 9, 2, 2, 10, 0},
        '{65535, 1, 3, 3, 33, 1}, '{12, 300, 5, 4, 8, 1}, '{0, 0, 6, 1, 0, 0},
        '{30, 40, 7, 2, 16, 1}
    };

    initial begin
        int cnt;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset busy", busy, 0);
        check("reset late", late, 0);
        check("reset vis0", o_vis[0], 0);
        check("reset cos0", o_cos[0], 0);
        rst = 1'b0;

        // Test 1: rot 0; busy length; commit values
        for (int i = 0; i < NUM_SHAPES; i++)
            write_entry(i, init_tab[i][0], init_tab[i][1], init_tab[i][2], init_tab[i][3], init_tab[i][4], init_tab[i][5] != 0);
        write_entry(7, 999, 999, 4, 4, 99, 1'b1);
        pulse_start();
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
        check("t1 busy cycles", cnt, 42);
        pulse_newframe();
        check("t1 late", late, 0);
        check("t1 cos0", o_cos[0], 4096);
        check("t1 sin0", o_sin[0], 0);
        check("t1 ix0", o_ix[0], -409600);
        check("t1 iy0", o_iy[0], -204800);
        check("t1 vis0", o_vis[0], 1);
        check("t1 ty0", o_ty[0], 1);

        // Test 2: 90 degrees
        write_entry(0, 100, 50, 2, 1, 20, 1'b1);
        pulse_start(); wait_not_busy("t2"); pulse_newframe();
        check("t2 sin0", o_sin[0], 4096);
        check("t2 cos0", o_cos[0], 0);
        check("t2 ix0", o_ix[0], 204800);
        check("t2 iy0", o_iy[0], -409600);

        // Test 3: 45 degrees
        write_entry(0, 100, 50, 1, 1, 20, 1'b1);
        pulse_start(); wait_not_busy("t3"); pulse_newframe();
        check("t3 sin0", o_sin[0], 2896);
        check("t3 cos0", o_cos[0], 2896);
        check("t3 ix0", o_ix[0], -144800);
        check("t3 iy0", o_iy[0], -434400);

        // Test 4: newframe mid-computation is late and commits nothing
        write_entry(0, 100, 50, 0, 1, 20, 1'b1);
        pulse_start();
        repeat (8) @(negedge clk);
        pulse_newframe();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (late === 1'b1) cnt++;
            @(negedge clk);
        end
        check("t4 late pulses", cnt, 1);
        check("t4 ix0 held", o_ix[0], -144800);
        wait_not_busy("t4");
        pulse_newframe();
        check("t4 ix0 commit", o_ix[0], -409600);
        check("t4 late on commit", late, 0);

        // Test 5: rewrite entry 6 during entry 2, entry 0 after its store
        pulse_start();
        repeat (14) @(negedge clk);
        write_entry(6, 10, 20, 0, 2, 16, 1'b1);
        write_entry(0, 200, 0, 0, 1, 20, 1'b1);
        wait_not_busy("t5");
        pulse_newframe();
        check("t5 ix6 new", o_ix[6], -40960);
        check("t5 iy6 new", o_iy[6], -81920);
        check("t5 ix0 old", o_ix[0], -409600);
        pulse_start(); wait_not_busy("t5b");
        // Commit and restart in the same cycle.
        start = 1'b1; newframe = 1'b1;
        @(negedge clk);
        start = 1'b0; newframe = 1'b0;
        check("t5 ix0 next frame", o_ix[0], -819200);
        check("t5 iy0 next frame", o_iy[0], 0);
        check("t5 restart busy", busy, 1);
        wait_not_busy("t5c");
        pulse_newframe();
        pulse_newframe();
        check("idle newframe late", late, 0);

        // Test 6: reset during MUL2 of entry 0
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 busy after rst", busy, 0);
        check("t6 vis0 after rst", o_vis[0], 0);
        check("t6 ix0 after rst", o_ix[0], 0);
        check("t6 ty6 after rst", o_ty[6], 0);
        rst = 1'b0;
        write_entry(0, 100, 50, 1, 3, 5, 1'b1);
        pulse_start(); wait_not_busy("t6"); pulse_newframe();
        check("t6 ix0", o_ix[0], -144800);
        check("t6 iy0", o_iy[0], -434400);
        check("t6 ty0", o_ty[0], 3);
        check("t6 vis1", o_vis[1], 0);
        check("t6 cos1", o_cos[1], 4096);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shape_setup.md
Name: shape_setup

Overview:
- Per-frame setup stage directly upstream of the per-shape rasterisers (render_shape instances).
- Holds the shape table written by game logic: screen position, rotation step, type, size, enable.
- At vblank it computes, for every shape, the sin/cos step values and the local-space origin (ix, iy) the rasteriser needs at screen pixel (0,0).
- Results are double-buffered and committed on newframe, so rasterisers see parameters that are stable for a whole frame.

Parameters:
- NUM_SHAPES, 7, number of shape slots (tangram pieces).
- ROT_STEPS, 8, rotation steps per full turn (45° each); rotation index width is clog2(ROT_STEPS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write one shape-table entry this cycle
- wr_idx  in  clog2(NUM_SHAPES)  entry index
- wr_x, wr_y  in  INT_BITS  unsigned screen anchor of shape
- wr_rot  in  clog2(ROT_STEPS)  rotation step
- wr_ty  in  INT_BITS  shape type (0..4, rasteriser encoding)
- wr_size  in  INT_BITS  shape size
- wr_vis  in  1  shape visible
- start  in  1  vblank pulse, begin computation
- newframe  in  1  same pulse the rasterisers receive; commit point
- busy  out  1  computation in progress
- late  out  1  one-cycle pulse: newframe arrived before computation finished
- o_ty[NUM_SHAPES], o_size[NUM_SHAPES]  out  INT_BITS  committed type/size
- o_sin[NUM_SHAPES], o_cos[NUM_SHAPES], o_ix[NUM_SHAPES], o_iy[NUM_SHAPES]  out  FLOAT_BITS signed  committed rasteriser inputs
- o_vis[NUM_SHAPES]  out  1  committed visibility

Behaviour:
- Reset:
  - Shape table cleared: vis=0, all fields 0.
  - Shadow and committed banks zeroed; busy=0, late=0; FSM in IDLE.
  - Reset mid-computation aborts it; nothing is committed.
- Table write:
  - wr_en writes the entry in the same cycle.
  - The FSM latches an entry in LOAD. A write to an entry already processed this frame takes effect in the next frame.
  - wr_idx >= NUM_SHAPES is ignored.
- Trig LUT: constant, indexed by rot. Values are Q(FLOAT_DCM_BITS). At 45°, the value is round(2^DCM·√2/2). Entries for 90° and 180° are exact (±2^DCM or 0).
- Math:
  - ix = -(x·cos - y·sin)
  - iy = -(x·sin + y·cos)
  - so that local coordinates are 0 at the shape anchor.
  - x and y are zero-extended to signed before multiplying.
  - Products and sums are truncated (two's-complement wrap) to FLOAT_BITS.
  - A single shared signed multiplier performs all products.
- FSM:
  - IDLE: start -> LOAD(i=0); busy=1 from the next cycle.
  - LOAD: latch entry i and LUT sin/cos (1 cycle).
  - MUL0..MUL3: x·cos, y·sin, x·sin, y·cos, one per cycle, accumulated into ix/iy.
  - STORE: write shadow[i], including ty/size/vis/sin/cos. If i=NUM_SHAPES-1 -> READY, else LOAD(i+1).
  - Timing: 6 cycles per shape. busy falls in READY, which is entered 6·NUM_SHAPES cycles after start is accepted.
  - READY: waits for newframe. On newframe, committed <= shadow for all shapes in one cycle, then -> IDLE.
- start while not IDLE: ignored.
- newframe while busy (LOAD..STORE):
  - committed bank unchanged; late pulses 1 cycle.
  - Computation continues and commits at the following newframe.
- newframe in IDLE: no change, no late.
- start and newframe in the same cycle while READY: commit first, then go to LOAD (the start is accepted).
- Invisible shapes are still computed and committed.

Decomposition:
- Shared package (with existing constants): rotation index width, the ROT_STEPS trig LUT function, and the shape_entry_t struct (x, y, rot, ty, size, vis).
- The committed bank is typed as shape_params_t (ty, size, sin, cos, ix, iy, vis).
- One natural sub-module: shape_setup_mac. It holds the shared multiplier plus the ix/iy accumulators and is sequenced by the FSM.

Test Plan (FLOAT_DCM_BITS=12, NUM_SHAPES=7):
1. Entry 0 at x=100, y=50, rot=0; start; 42 cycles later newframe -> o_cos[0]=4096, o_sin[0]=0, o_ix[0]=-409600, o_iy[0]=-204800; busy high for exactly 42 cycles; late=0.
2. Same entry with rot=2 (90°) -> sin=4096, cos=0, ix=204800, iy=-409600.
3. Same entry with rot=1 (45°) -> sin=cos=2896, ix=-144800, iy=-434400.
4. newframe 10 cycles after start -> late pulses once, outputs keep their previous values; next newframe commits the new values.
5. Rewrite entry 6 during the computation of entry 2 -> the current frame commits the new entry-6 values. Rewrite entry 0 after its STORE -> the old value is committed; the new value is committed the following frame.
6. Assert rst during MUL2 -> busy=0 next cycle, all outputs 0, vis=0; a subsequent start/newframe cycle computes correctly from the table rewritten after reset.
